bus_drvr_fifo_agent: RTL and testbench
======================================

BUS_DRVR_FIFO_AGENT -- requirements
Module: bus_drvr_fifo_agent

Interface
REQ-001 Parameter bits, default 32: packet width on bus and host sides.
REQ-002 Parameter depth, default 8: entries per FIFO; power of two, >= 2.
REQ-003 Parameter drvr_id, default 0: this agent's 8-bit bus address.
REQ-004 Parameter broadcast, default {8{1'b1}}: 8-bit destination value addressed to all drivers.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pndng  output  1  TX FIFO non-empty, presented to bus arbiter.
REQ-008 pop  input  1  bus arbiter consumes TX head this cycle.
REQ-009 D_pop  output  bits  TX FIFO head word, first-word-fall-through.
REQ-010 push  input  1  bus delivers a word to this agent this cycle.
REQ-011 D_push  input  bits  delivered word; destination field D_push[bits-1:bits-8].
REQ-012 tx_wr  input  1  host write strobe into TX FIFO.
REQ-013 tx_data  input  bits  host write data.
REQ-014 tx_full  output  1  TX count == depth.
REQ-015 rx_rd  input  1  host read strobe from RX FIFO.
REQ-016 rx_data  output  bits  RX FIFO head word, first-word-fall-through.
REQ-017 rx_empty  output  1  RX count == 0.
REQ-018 rx_count  output  $clog2(depth)+1  RX occupancy.
REQ-019 rx_overflow  output  1  sticky: a deliverable word was dropped because RX was full.

Function
REQ-020 TX and RX each SHALL be a circular buffer with wrap-around read/write pointers and a $clog2(depth)+1-bit occupancy counter.
REQ-021 pndng SHALL equal (TX count != 0); D_pop SHALL show the head entry combinationally from storage with zero latency.
REQ-022 tx_wr SHALL be accepted only when tx_full==0; tx_wr while full SHALL be ignored even if pop is asserted the same cycle.
REQ-023 pop SHALL advance the TX read pointer only when pndng==1; pop while empty SHALL be ignored with no pointer or count change.
REQ-024 Simultaneous accepted tx_wr and valid pop SHALL leave TX count unchanged; a word written into an empty FIFO SHALL appear on D_pop and pndng the next cycle.
REQ-025 A push word SHALL be deliverable when its destination field equals drvr_id or broadcast (subject to REQ-033).
REQ-026 A deliverable word SHALL be stored when RX count < depth; when RX is full it SHALL be dropped and rx_overflow set to 1 the following cycle.
REQ-027 rx_rd SHALL advance the RX read pointer only when rx_empty==0; rx_rd while empty SHALL be ignored.
REQ-028 Simultaneous stored push and valid rx_rd SHALL leave rx_count unchanged; push into a full RX with rx_rd the same cycle SHALL still be dropped (full evaluated on registered count).
REQ-029 rx_overflow SHALL remain 1 until reset.
REQ-030 TX and RX paths SHALL be fully independent; no combinational path from pop to pndng or from push to rx_empty.

Reset
REQ-031 On a clock edge with reset=1, both pointers and counts SHALL clear and rx_overflow SHALL clear; pndng=0, tx_full=0, rx_empty=1, rx_count=0 next cycle.
REQ-032 Reset SHALL override all simultaneous tx_wr, pop, push and rx_rd; storage contents need not clear, and D_pop/rx_data are don't-care while empty.

Configuration
REQ-033 Macro BUS_DRVR_ADDR_FILTER_EN: when defined, destination filtering per REQ-025 applies; when undefined, every push word is deliverable regardless of destination field.

Verification
REQ-034 Reset, then tx_wr 0x0100_00AA, 0x0100_00BB -> pndng=1, D_pop=0x0100_00AA; pop -> D_pop=0x0100_00BB; pop -> pndng=0.
REQ-035 Write 8 words (depth=8) -> tx_full=1; 9th tx_wr with pop same cycle -> 9th word dropped, count=7, order preserved.
REQ-036 drvr_id=3, filter on: push 0x0300_0001, 0x0500_0002, 0xFF00_0003 -> rx_count=2, rx_data sequence 0x0300_0001, 0xFF00_0003; filter off -> rx_count=3.
REQ-037 Fill RX to 8, push deliverable word -> rx_count stays 8, rx_overflow=1 and stays 1 after draining with rx_rd.
REQ-038 Pointer wrap: 20 interleaved write/read pairs on both FIFOs -> data in order, counts never exceed 1.
REQ-039 Assert reset with TX=5, RX=4 while pop and push active -> next cycle pndng=0, rx_empty=1, rx_overflow=0.

Source files
------------

// File: rtl/bus_drvr_fifo_agent.sv
// Bus driver FIFO agent: a TX FIFO that the host fills and the bus arbiter
// drains, and an RX FIFO that the bus fills and the host drains. Both FIFOs
// are first-word-fall-through circular buffers with independent pointers.
//
// Optional build macro:
//   BUS_DRVR_ADDR_FILTER_EN - when defined, only bus words whose destination
//   byte matches drvr_id or broadcast are accepted into RX. When undefined,
//   every pushed word is accepted.
module bus_drvr_fifo_agent #(
  parameter int unsigned bits      = 32,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  drvr_id   = 8'd0,
  parameter logic [7:0]  broadcast = {8{1'b1}}
) (
  input  logic                    clk,
  input  logic                    reset,
  // Bus side
  output logic                    pndng,
  input  logic                    pop,
  output logic [bits-1:0]         D_pop,
  input  logic                    push,
  input  logic [bits-1:0]         D_push,
  // Host side
  input  logic                    tx_wr,
  input  logic [bits-1:0]         tx_data,
  output logic                    tx_full,
  input  logic                    rx_rd,
  output logic [bits-1:0]         rx_data,
  output logic                    rx_empty,
  output logic [$clog2(depth):0]  rx_count,
  output logic                    rx_overflow
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

`ifdef BUS_DRVR_ADDR_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- TX path
  logic [bits-1:0] tx_mem [depth];
  logic [AW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0]   tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0]   tx_cnt_q,    tx_cnt_d;
  logic            tx_wr_ok, tx_rd_ok;

  // Full/empty come only from the registered count, so pop never reaches pndng
  // and a write while full stays rejected even if pop frees a slot this cycle.
  assign tx_full  = (tx_cnt_q == DEPTH_C);
  assign pndng    = (tx_cnt_q != '0);
  assign tx_wr_ok = tx_wr & ~tx_full;
  assign tx_rd_ok = pop & pndng;
  assign D_pop    = tx_mem[tx_rd_ptr_q];

  // Next-state for TX pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_wr_ok) tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
    if (tx_rd_ok) tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
    tx_cnt_d = tx_cnt_q + CW'(tx_wr_ok) - CW'(tx_rd_ok);
  end

  // TX control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  // TX storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the cleared pointers make stale entries invisible.
    if (tx_wr_ok) tx_mem[tx_wr_ptr_q] <= tx_data;
  end

  // ---------------------------------------------------------------- RX path
  logic [bits-1:0] rx_mem [depth];
  logic [AW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0]   rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]   rx_cnt_q,    rx_cnt_d;
  logic            rx_ovf_q,    rx_ovf_d;
  logic [7:0]      push_dest;
  logic            addr_match, deliverable, rx_full;
  logic            rx_store, rx_drop, rx_rd_ok;

  assign push_dest   = D_push[bits-1 -: 8];
  assign addr_match  = (push_dest == drvr_id) || (push_dest == broadcast);
  assign deliverable = push & (addr_match | ~FILTER_EN);
  assign rx_full     = (rx_cnt_q == DEPTH_C);
  assign rx_store    = deliverable & ~rx_full;
  assign rx_drop     = deliverable &  rx_full;

  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_rd_ok    = rx_rd & ~rx_empty;
  assign rx_count    = rx_cnt_q;
  assign rx_overflow = rx_ovf_q;
  assign rx_data     = rx_mem[rx_rd_ptr_q];

  // Next-state for RX pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    if (rx_store) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
    if (rx_rd_ok) rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
    rx_cnt_d = rx_cnt_q + CW'(rx_store) - CW'(rx_rd_ok);
    rx_ovf_d = rx_ovf_q | rx_drop;
  end

  // RX control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

  // RX storage write.
  always_ff @(posedge clk) begin
    if (rx_store) rx_mem[rx_wr_ptr_q] <= D_push;
  end

endmodule

// File: tb/tb_bus_drvr_fifo_agent.sv
// Directed self-checking bench for bus_drvr_fifo_agent (bits=32, depth=8,
// drvr_id=3). Expectations for the RX filter test follow whether
// BUS_DRVR_ADDR_FILTER_EN is defined for the build.
module tb_bus_drvr_fifo_agent;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng, pop, push, tx_wr, tx_full, rx_rd, rx_empty, rx_overflow;
  logic [31:0] D_pop, D_push, tx_data, rx_data;
  logic [3:0]  rx_count;

  int checks = 0;
  int errors = 0;

  bus_drvr_fifo_agent #(
    .bits(32), .depth(8), .drvr_id(8'h03), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_count(rx_count), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs were set before, outputs settle #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; pop = 1'b0; push = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0;
  endtask

  task automatic tx_write(input logic [31:0] d);
    tx_wr = 1'b1; tx_data = d; tick(); tx_wr = 1'b0;
  endtask

  task automatic rx_push(input logic [31:0] d);
    push = 1'b1; D_push = d; tick(); push = 1'b0;
  endtask

  initial begin
    idle();
    tx_data = '0; D_push = '0;

    // Reset state
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_pndng",    pndng,       1'b0);
    check("rst_tx_full",  tx_full,     1'b0);
    check("rst_rx_empty", rx_empty,    1'b1);
    check("rst_rx_count", rx_count,    4'd0);
    check("rst_rx_ovf",   rx_overflow, 1'b0);

    // Basic TX write / pop with fall-through head
    tx_write(32'h0100_00AA);
    check("tx1_pndng", pndng, 1'b1);
    check("tx1_head",  D_pop, 32'h0100_00AA);
    tx_write(32'h0100_00BB);
    check("tx2_head",  D_pop, 32'h0100_00AA);
    pop = 1'b1; tick();
    check("pop1_head", D_pop, 32'h0100_00BB);
    check("pop1_pndng", pndng, 1'b1);
    tick(); pop = 1'b0;
    check("pop2_pndng", pndng, 1'b0);
    // Pop while empty must be ignored
    pop = 1'b1; tick(); pop = 1'b0;
    check("pop_empty_pndng", pndng, 1'b0);
    tx_write(32'h0100_00CC);
    check("after_empty_pop_head", D_pop, 32'h0100_00CC);
    pop = 1'b1; tick(); pop = 1'b0;
    check("tx_drained", pndng, 1'b0);

    // Fill TX, then write-while-full with pop in the same cycle
    for (int i = 0; i < 8; i++) begin
      check("fill_not_full", tx_full, 1'b0);
      tx_write(32'h0000_1000 + i);
    end
    check("tx_full_set", tx_full, 1'b1);
    check("full_head",   D_pop,   32'h0000_1000);
    tx_wr = 1'b1; tx_data = 32'hDEAD_BEEF; pop = 1'b1; tick();
    tx_wr = 1'b0; pop = 1'b0;
    check("ovr_full_clr", tx_full, 1'b0);
    for (int i = 1; i < 8; i++) begin
      check("drain_pndng", pndng, 1'b1);
      check("drain_order", D_pop, 32'h0000_1000 + i);
      pop = 1'b1; tick(); pop = 1'b0;
    end
    check("drain_empty", pndng, 1'b0);

    // RX destination filtering
    rx_push(32'h0300_0001);
    rx_push(32'h0500_0002);
    rx_push(32'hFF00_0003);
`ifdef BUS_DRVR_ADDR_FILTER_EN
    check("filt_count", rx_count, 4'd2);
    check("filt_head0", rx_data, 32'h0300_0001);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    check("filt_head1", rx_data, 32'hFF00_0003);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
`else
    check("nofilt_count", rx_count, 4'd3);
    check("nofilt_head0", rx_data, 32'h0300_0001);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    check("nofilt_head1", rx_data, 32'h0500_0002);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    check("nofilt_head2", rx_data, 32'hFF00_0003);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
`endif
    check("filt_empty", rx_empty, 1'b1);
    // rx_rd while empty must be ignored
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    check("rd_empty_count", rx_count, 4'd0);
    check("rd_empty_flag",  rx_empty, 1'b1);
    check("no_ovf_yet",     rx_overflow, 1'b0);

    // RX overflow: fill, drop, drop-with-read, sticky flag
    for (int i = 0; i < 8; i++) rx_push(32'h0300_0010 + i);
    check("rx_fill_count", rx_count, 4'd8);
    check("rx_fill_ovf",   rx_overflow, 1'b0);
    rx_push(32'h0300_00FF);
    check("rx_drop_count", rx_count, 4'd8);
    check("rx_drop_ovf",   rx_overflow, 1'b1);
    push = 1'b1; D_push = 32'h0300_00EE; rx_rd = 1'b1; tick();
    push = 1'b0; rx_rd = 1'b0;
    check("rx_droprd_count", rx_count, 4'd7);
    for (int i = 1; i < 8; i++) begin
      check("rx_drain_order", rx_data, 32'h0300_0010 + i);
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    end
    check("rx_drain_empty", rx_empty, 1'b1);
    check("rx_ovf_sticky",  rx_overflow, 1'b1);

    // Pointer wrap with simultaneous write/read keeping occupancy at one
    tx_wr = 1'b1; tx_data = 32'hA000_0000; push = 1'b1; D_push = 32'h0300_0000;
    tick();
    for (int i = 1; i <= 20; i++) begin
      tx_data = 32'hA000_0000 + i; D_push = 32'h0300_0000 + i;
      pop = 1'b1; rx_rd = 1'b1;
      tick();
      check("wrap_tx_head", D_pop, 32'hA000_0000 + i);
      check("wrap_rx_head", rx_data, 32'h0300_0000 + i);
      check("wrap_rx_count", rx_count, 4'd1);
      check("wrap_pndng", pndng, 1'b1);
    end
    tx_wr = 1'b0; push = 1'b0;
    tick(); pop = 1'b0; rx_rd = 1'b0;
    check("wrap_tx_empty", pndng, 1'b0);
    check("wrap_rx_empty", rx_empty, 1'b1);

    // Reset overrides simultaneous activity
    for (int i = 0; i < 5; i++) tx_write(32'hB000_0000 + i);
    for (int i = 0; i < 4; i++) rx_push(32'h0300_0100 + i);
    check("pre_rst_rx_count", rx_count, 4'd4);
    check("pre_rst_ovf", rx_overflow, 1'b1);
    reset = 1'b1; pop = 1'b1; push = 1'b1; D_push = 32'h0300_0999;
    tx_wr = 1'b1; tx_data = 32'hC000_0000; rx_rd = 1'b1;
    tick();
    idle();
    check("rst2_pndng",    pndng,       1'b0);
    check("rst2_rx_empty", rx_empty,    1'b1);
    check("rst2_rx_ovf",   rx_overflow, 1'b0);
    check("rst2_tx_full",  tx_full,     1'b0);
    check("rst2_rx_count", rx_count,    4'd0);
    tick();
    check("rst2_hold_pndng", pndng, 1'b0);
    check("rst2_hold_rx",    rx_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
